// File: rtl/mem_stage_pkg.sv
// Shared types, strobe constants and lane helpers for the load/store memory stage.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        OP_LB   = 4'd0,
        OP_LH   = 4'd1,
        OP_LW   = 4'd2,
        OP_LBU  = 4'd3,
        OP_LHU  = 4'd4,
        OP_SB   = 4'd5,
        OP_SH   = 4'd6,
        OP_SW   = 4'd7,
        OP_NONE = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_ACCESS2 = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    function automatic logic op_is_mem(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: op_is_mem = 1'b1;
            default:             op_is_mem = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        case (op)
            OP_SB, OP_SH, OP_SW: op_is_store = 1'b1;
            default:             op_is_store = 1'b0;
        endcase
    endfunction

    // Unshifted byte-enable pattern for the access width.
    function automatic logic [3:0] op_base_strb(input mem_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_base_strb = STRB_BYTE;
            OP_LH, OP_LHU, OP_SH: op_base_strb = STRB_HALF;
            OP_LW, OP_SW:         op_base_strb = STRB_WORD;
            default:              op_base_strb = STRB_NONE;
        endcase
    endfunction

    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] lane);
        case (op_base_strb(op))
            STRB_HALF: op_misaligned = lane[0];
            STRB_WORD: op_misaligned = (lane != 2'd0);
            default:   op_misaligned = 1'b0;
        endcase
    endfunction

    // True only when the access spills into the next word.
    function automatic logic op_crosses(input mem_op_t op, input logic [1:0] lane);
        case (op_base_strb(op))
            STRB_HALF: op_crosses = (lane == 2'd3);
            STRB_WORD: op_crosses = (lane != 2'd0);
            default:   op_crosses = 1'b0;
        endcase
    endfunction

    // Replicate narrow data, then rotate so every byte sits in its lane for both beats.
    function automatic logic [31:0] store_lanes(input mem_op_t op, input logic [31:0] wd,
                                                input logic [1:0] lane);
        logic [31:0] repl;
        logic [63:0] dbl;
        case (op)
            OP_SB:   repl = {4{wd[7:0]}};
            OP_SH:   repl = {2{wd[15:0]}};
            default: repl = wd;
        endcase
        dbl = {repl, repl} << {lane, 3'b000};
        store_lanes = dbl[63:32];
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed bytes from one or two bus words and extends them to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] lo_word_i,
    input  logic [31:0] hi_word_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted_s;

    // Shift the addressed byte down to bit 0, then extend by access type.
    always_comb begin
        shifted_s = 32'({hi_word_i, lo_word_i} >> {lane_i, 3'b000});
        case (op_i)
            OP_LB:   data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            OP_LBU:  data_o = {24'd0, shifted_s[7:0]};
            OP_LH:   data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            OP_LHU:  data_o = {16'd0, shifted_s[15:0]};
            default: data_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store unit with a req/ready bus. Define MEM_MISALIGN_TRAP_EN to fault
// misaligned accesses; otherwise word-crossing accesses are split into two bus beats.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enabled,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        completed,
    output logic [31:0] result,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    state_t      state_q, state_d;
    mem_op_t     op_q, op_d;
    mem_op_t     op_in_s;
    logic [1:0]  lane_q, lane_d;
    logic        split_q, split_d;
    logic [3:0]  strb_hi_q, strb_hi_d;
    logic [31:0] rdata_lo_q, rdata_lo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        completed_q, completed_d;
    logic [31:0] result_q, result_d;
    logic        fault_q, fault_d;
    logic [7:0]  strb8_s;
    logic [31:0] align_lo_s, align_hi_s, aligned_s, finish_s;

    assign op_in_s = mem_op_t'(op);

    // The second beat of a split load merges the held first word with the live bus word.
    assign align_lo_s = (state_q == ST_ACCESS2) ? rdata_lo_q : mem_rdata;
    assign align_hi_s = (state_q == ST_ACCESS2) ? mem_rdata : 32'd0;
    assign finish_s   = op_is_store(op_q) ? 32'd0 : aligned_s;

    load_align u_load_align (
        .op_i      (op_q),
        .lane_i    (lane_q),
        .lo_word_i (align_lo_s),
        .hi_word_i (align_hi_s),
        .data_o    (aligned_s)
    );

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        split_d     = split_q;
        strb_hi_d   = strb_hi_q;
        rdata_lo_d  = rdata_lo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        completed_d = 1'b0;
        result_d    = result_q;
        fault_d     = fault_q;
        strb8_s     = {4'b0000, op_base_strb(op_in_s)} << addr[1:0];

        case (state_q)
            ST_IDLE: begin
                if (enabled) begin
                    op_d   = op_in_s;
                    lane_d = addr[1:0];
                    if (!op_is_mem(op)) begin
                        state_d     = ST_DONE;
                        completed_d = 1'b1;
                        result_d    = addr;
                        fault_d     = 1'b0;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (op_misaligned(op_in_s, addr[1:0])) begin
                        state_d     = ST_DONE;
                        completed_d = 1'b1;
                        result_d    = addr;
                        fault_d     = 1'b1;
                    end
`endif
                    else begin
                        state_d     = ST_ACCESS;
                        split_d     = op_crosses(op_in_s, addr[1:0]);
                        mem_req_d   = 1'b1;
                        mem_we_d    = op_is_store(op_in_s);
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wstrb_d = op_is_store(op_in_s) ? strb8_s[3:0] : STRB_NONE;
                        strb_hi_d   = op_is_store(op_in_s) ? strb8_s[7:4] : STRB_NONE;
                        mem_wdata_d = store_lanes(op_in_s, wdata, addr[1:0]);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_req_q && mem_ready) begin
                    if (split_q) begin
                        state_d     = ST_ACCESS2;
                        rdata_lo_d  = mem_rdata;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_wstrb_d = strb_hi_q;
                    end else begin
                        state_d     = ST_DONE;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_wstrb_d = STRB_NONE;
                        completed_d = 1'b1;
                        result_d    = finish_s;
                        fault_d     = 1'b0;
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS2: begin
                if (mem_req_q && mem_ready) begin
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = STRB_NONE;
                    completed_d = 1'b1;
                    result_d    = finish_s;
                    fault_d     = 1'b0;
                end else begin
                    state_d = ST_ACCESS2;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NONE;
            lane_q      <= 2'd0;
            split_q     <= 1'b0;
            strb_hi_q   <= 4'd0;
            rdata_lo_q  <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'd0;
            mem_wdata_q <= 32'd0;
            completed_q <= 1'b0;
            result_q    <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            split_q     <= split_d;
            strb_hi_q   <= strb_hi_d;
            rdata_lo_q  <= rdata_lo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            completed_q <= completed_d;
            result_q    <= result_d;
            fault_q     <= fault_d;
        end
    end

    assign completed = completed_q;
    assign result    = result_q;
    assign fault     = fault_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with a byte-level memory model
// and a randomly stalling bus responder.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enabled = 1'b0;
    logic [3:0]  op = 4'd8;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        completed, fault, mem_req, mem_we;
    logic [31:0] result, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    mem_stage dut (
        .clk(clk), .rst(rst), .enabled(enabled), .op(op), .addr(addr), .wdata(wdata),
        .completed(completed), .result(result), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] res; logic flt; bit beats; int issue_cyc; } exp_t;
    typedef struct { logic [31:0] a; logic we; logic [3:0] strb; logic [31:0] data; } beat_t;

    exp_t eq[$];
    beat_t bq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int last_beat_cyc = 0;
    bit stall_all = 1'b0;
    int force_delay = -1;
    bit wd_chk = 1'b0;
    logic [31:0] wd_chk_val = 32'd0;

    logic [7:0]  byte_m [logic [31:0]];
    logic [31:0] mem_w  [logic [29:0]];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return {wa[13:0], 2'b10, ~wa[15:0]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [7:0] model_byte(input logic [31:0] a);
        logic [31:0] w;
        if (byte_m.exists(a)) return byte_m[a];
        w = init_word(a[31:2]);
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] bus_word(input logic [29:0] wa);
        if (mem_w.exists(wa)) return mem_w[wa];
        return init_word(wa);
    endfunction

    function automatic int op_size(input logic [3:0] o);
        case (o)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    task automatic preload(input logic [29:0] wa, input logic [31:0] w);
        mem_w[wa] = w;
        for (int i = 0; i < 4; i++) byte_m[{wa, 2'b00} + 32'(i)] = w[8*i +: 8];
    endtask

    // Predict the response and bus beats from byte semantics, then drive one transaction.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        beat_t b0, b1;
        int sz, waited;
        bit st, two;
        logic [31:0] v;
        sz = op_size(o);
        st = (o == OP_SB) || (o == OP_SH) || (o == OP_SW);
        e.issue_cyc = cyc;
        e.flt = 1'b0;
        e.beats = 1'b0;
        e.res = a;
        if (sz != 0) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if ((a % sz) != 0) e.flt = 1'b1;
`endif
            if (!e.flt) begin
                e.beats = 1'b1;
                v = 32'd0;
                b0 = '{{a[31:2], 2'b00}, st, 4'd0, 32'd0};
                b1 = '{{a[31:2], 2'b00} + 32'd4, st, 4'd0, 32'd0};
                two = ((a + 32'(sz) - 32'd1) >> 2) != (a >> 2);
                for (int i = 0; i < sz; i++) begin
                    logic [31:0] ba;
                    ba = a + 32'(i);
                    if (st) begin
                        byte_m[ba] = wd[8*i +: 8];
                        if (ba[31:2] == a[31:2]) begin
                            b0.strb[ba[1:0]] = 1'b1;
                            b0.data[8*ba[1:0] +: 8] = wd[8*i +: 8];
                        end else begin
                            b1.strb[ba[1:0]] = 1'b1;
                            b1.data[8*ba[1:0] +: 8] = wd[8*i +: 8];
                        end
                    end else begin
                        v[8*i +: 8] = model_byte(ba);
                    end
                end
                if (st) e.res = 32'd0;
                else if (o == OP_LB) e.res = {{24{v[7]}}, v[7:0]};
                else if (o == OP_LH) e.res = {{16{v[15]}}, v[15:0]};
                else e.res = v;
                bq.push_back(b0);
                if (two) bq.push_back(b1);
            end
        end
        eq.push_back(e);
        enabled = 1'b1; op = o; addr = a; wdata = wd;
        @(negedge clk);
        waited = 0;
        while (completed !== 1'b1 && waited < 100) begin
            enabled = ($urandom_range(0, 2) == 0);
            op = 4'($urandom_range(0, 8));
            addr = $urandom;
            wdata = $urandom;
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no completed within %0d cycles", waited);
        end
        enabled = 1'b0;
        @(negedge clk);
    endtask

    // Bus responder: random stalls, beat checks, stability checks, word memory.
    initial begin : responder
        bit prev_req, prev_stall, go;
        int stall_cnt;
        logic [31:0] s_addr, s_wdata;
        logic s_we;
        logic [3:0] s_strb;
        beat_t b;
        logic [31:0] w;
        prev_req = 1'b0; prev_stall = 1'b0; stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ready = 1'b0; prev_req = 1'b0; prev_stall = 1'b0; stall_cnt = 0;
                continue;
            end
            if (prev_stall && mem_req) begin
                chk("stable_addr", mem_addr, s_addr);
                chk("stable_we", 32'(mem_we), 32'(s_we));
                chk("stable_wstrb", 32'(mem_wstrb), 32'(s_strb));
                chk("stable_wdata", mem_wdata, s_wdata);
            end
            if (mem_req && !prev_req) chk("unexpected_req", 32'(bq.size() != 0), 32'd1);
            prev_req = mem_req;
            if (mem_req) begin
                if (stall_all) go = 1'b0;
                else if (force_delay >= 0) go = (stall_cnt >= force_delay);
                else go = ($urandom_range(0, 1) == 0);
                if (go && bq.size() != 0) begin
                    b = bq.pop_front();
                    chk("beat_addr", mem_addr, b.a);
                    chk("beat_we", 32'(mem_we), 32'(b.we));
                    chk("beat_wstrb", 32'(mem_wstrb), 32'(b.strb));
                    w = bus_word(mem_addr[31:2]);
                    for (int i = 0; i < 4; i++) begin
                        if (b.strb[i]) begin
                            chk("beat_wdata_lane", 32'(mem_wdata[8*i +: 8]), 32'(b.data[8*i +: 8]));
                            if (mem_we) w[8*i +: 8] = mem_wdata[8*i +: 8];
                        end
                    end
                    if (wd_chk) begin
                        chk("store_wdata_word", mem_wdata, wd_chk_val);
                        wd_chk = 1'b0;
                    end
                    if (mem_we) mem_w[mem_addr[31:2]] = w;
                    mem_rdata = bus_word(mem_addr[31:2]);
                    mem_ready = 1'b1;
                    last_beat_cyc = cyc;
                    stall_cnt = 0;
                    prev_stall = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    stall_cnt++;
                    prev_stall = 1'b1;
                    s_addr = mem_addr; s_we = mem_we; s_strb = mem_wstrb; s_wdata = mem_wdata;
                end
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
                prev_stall = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each completed pulse and checks held outputs otherwise.
    initial begin : monitor
        exp_t e;
        logic [31:0] held_res;
        logic held_flt;
        bit prev_done;
        held_res = 32'd0; held_flt = 1'b0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_res = 32'd0; held_flt = 1'b0; prev_done = 1'b0;
                continue;
            end
            if (completed) begin
                chk("completed_single_cycle", 32'(prev_done), 32'd0);
                if (eq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_completed: got completed with nothing outstanding");
                end else begin
                    e = eq.pop_front();
                    chk("result", result, e.res);
                    chk("fault", 32'(fault), 32'(e.flt));
                    chk("latency", 32'(cyc), 32'(e.beats ? last_beat_cyc + 1 : e.issue_cyc + 1));
                end
                held_res = result; held_flt = fault;
            end else begin
                chk("result_hold", result, held_res);
                chk("fault_hold", 32'(fault), 32'(held_flt));
            end
            prev_done = completed;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [3:0] o;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        chk("rst_completed", 32'(completed), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        preload(30'h40, 32'h80FF_0000);
        force_delay = 0;
        issue(OP_LB, 32'h0000_0103, 32'd0);
        wd_chk = 1'b1; wd_chk_val = 32'hBEEF_BEEF;
        issue(OP_SH, 32'h0000_0202, 32'h0000_BEEF);
        chk("store_wdata_seen", 32'(wd_chk), 32'd0);
        force_delay = 5;
        issue(OP_LW, 32'h0000_0040, 32'd0);
        force_delay = -1;
        issue(OP_NONE, 32'h1234_5678, 32'd0);
        preload(30'h40, 32'hAABB_CCDD);
        preload(30'h41, 32'h1122_3344);
        issue(OP_LW, 32'h0000_0102, 32'd0);
        issue(OP_LH, 32'h0000_0107, 32'd0);
        issue(OP_SW, 32'h0000_0101, 32'hCAFE_F00D);
        issue(OP_LW, 32'h0000_0101, 32'd0);

        // Reset in the middle of a stalled access.
        stall_all = 1'b1;
        bq.push_back('{32'h0000_0100, 1'b0, 4'd0, 32'd0});
        enabled = 1'b1; op = OP_LW; addr = 32'h0000_0100;
        @(negedge clk);
        enabled = 1'b0;
        @(negedge clk);
        chk("abort_req_before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_req_after", 32'(mem_req), 32'd0);
        chk("abort_completed", 32'(completed), 32'd0);
        rst = 1'b0;
        bq.delete();
        stall_all = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_completed", 32'(completed), 32'd0);
            chk("abort_result", result, 32'd0);
        end

        for (int n = 0; n < 300; n++) begin
            o = 4'($urandom_range(0, 8));
            a = 32'h100 + 32'($urandom_range(0, 31));
            issue(o, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(eq.size()), 32'd0);
        chk("beats_drained", 32'(bq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
